// File: rtl/rf_writeback_ctrl.sv
// Writeback arbiter for the 32x32 register file: ALU results and FIFO-buffered load results
// share one registered write port. Optional forwarding ports are enabled by RF_WB_FWD_EN.
module rf_writeback_ctrl #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_rd,
  input  logic [31:0]                alu_data,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic [4:0]                 mem_rd,
  input  logic [31:0]                mem_data,
  output logic                       mem_ready,
  output logic [4:0]                 rf_write_addr,
  output logic [31:0]                rf_write_data,
  output logic                       rf_reg_write,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       busy
`ifdef RF_WB_FWD_EN
  ,
  input  logic [4:0]                 fwd_addr_1,
  input  logic [4:0]                 fwd_addr_2,
  output logic                       fwd_hit_1,
  output logic                       fwd_hit_2,
  output logic [31:0]                fwd_data
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // Handshakes: a transfer happens in a cycle where valid && ready are both high at the
  // rising edge; producers hold rd/data stable while valid is high and ready is low.

  logic [36:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [SW-1:0] starve_cnt;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          force_mem;
  logic          grant_alu;
  logic          grant_mem;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  assign empty     = (fifo_count == '0);
  assign full      = (fifo_count == FULL_CNT);
  assign mem_ready = !full;
  assign push      = mem_valid && mem_ready;
  assign head_rd   = fifo_mem[rd_ptr][36:32];
  assign head_data = fifo_mem[rd_ptr][31:0];

  // Starved FIFO head wins even over a waiting ALU result.
  assign force_mem = (starve_cnt == STARVE_MAX) && !empty;
  assign grant_alu = alu_valid && !force_mem;
  assign grant_mem = force_mem || (!alu_valid && !empty);
  assign pop       = grant_mem;
  assign alu_ready = grant_alu;
  assign busy      = !empty || rf_reg_write;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {mem_rd, mem_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (empty || grant_mem) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // x0 writes are consumed but never strobe the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_write_addr <= '0;
      rf_write_data <= '0;
      rf_reg_write  <= 1'b0;
    end else if (grant_mem) begin
      rf_write_addr <= head_rd;
      rf_write_data <= head_data;
      rf_reg_write  <= (head_rd != 5'd0);
    end else if (grant_alu) begin
      rf_write_addr <= alu_rd;
      rf_write_data <= alu_data;
      rf_reg_write  <= (alu_rd != 5'd0);
    end else begin
      rf_reg_write  <= 1'b0;
    end
  end

`ifdef RF_WB_FWD_EN
  assign fwd_hit_1 = rf_reg_write && (fwd_addr_1 == rf_write_addr) && (fwd_addr_1 != 5'd0);
  assign fwd_hit_2 = rf_reg_write && (fwd_addr_2 == rf_write_addr) && (fwd_addr_2 != 5'd0);
  assign fwd_data  = rf_write_data;
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed bench for rf_writeback_ctrl (DEPTH=4, STARVE_LIMIT=3); hand-computed expectations.
module tb_rf_writeback_ctrl;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        rf_reg_write;
  logic [2:0]  fifo_count;
  logic        busy;
`ifdef RF_WB_FWD_EN
  logic [4:0]  fwd_addr_1;
  logic [4:0]  fwd_addr_2;
  logic        fwd_hit_1;
  logic        fwd_hit_2;
  logic [31:0] fwd_data;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  rf_writeback_ctrl #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .alu_ready     (alu_ready),
    .mem_valid     (mem_valid),
    .mem_rd        (mem_rd),
    .mem_data      (mem_data),
    .mem_ready     (mem_ready),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .rf_reg_write  (rf_reg_write),
    .fifo_count    (fifo_count),
    .busy          (busy)
`ifdef RF_WB_FWD_EN
    ,
    .fwd_addr_1    (fwd_addr_1),
    .fwd_addr_2    (fwd_addr_2),
    .fwd_hit_1     (fwd_hit_1),
    .fwd_hit_2     (fwd_hit_2),
    .fwd_data      (fwd_data)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Inputs change just after the falling edge; checks run 1ns later, mid-cycle.
  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    @(negedge clk);
    alu_valid = av;
    alu_rd    = ar;
    alu_data  = ad;
    mem_valid = mv;
    mem_rd    = mr;
    mem_data  = md;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".reg_write"}, {31'd0, rf_reg_write}, {31'd0, we});
    chk({tag, ".addr"}, {27'd0, rf_write_addr}, {27'd0, a});
    chk({tag, ".data"}, rf_write_data, d);
  endtask

  task automatic chk_cnt_is(input string tag, input int n);
    chk({tag, ".fifo_count"}, {29'd0, fifo_count}, 32'(n));
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
`ifdef RF_WB_FWD_EN
    fwd_addr_1 = '0; fwd_addr_2 = '0;
`endif
    repeat (2) @(negedge clk);
    #1;
    chk_wr("rst", 1'b0, 5'd0, 32'h0);
    chk_cnt_is("rst", 0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("rst.alu_ready", {31'd0, alu_ready}, 32'd0);
    reset = 1'b0;

    // single ALU write
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    chk("alu1.ready", {31'd0, alu_ready}, 32'd1);
    idle();
    chk_wr("alu1.wr", 1'b1, 5'd5, 32'hDEADBEEF);
    chk("alu1.busy", {31'd0, busy}, 32'd1);
`ifdef RF_WB_FWD_EN
    fwd_addr_1 = 5'd5; fwd_addr_2 = 5'd6;
    #1;
    chk("fwd.hit1", {31'd0, fwd_hit_1}, 32'd1);
    chk("fwd.hit2", {31'd0, fwd_hit_2}, 32'd0);
    chk("fwd.data", fwd_data, 32'hDEADBEEF);
    fwd_addr_1 = 5'd0;
    #1;
    chk("fwd.x0", {31'd0, fwd_hit_1}, 32'd0);
`endif
    idle();
    chk_wr("alu1.idle", 1'b0, 5'd5, 32'hDEADBEEF);
    chk("alu1.busy0", {31'd0, busy}, 32'd0);

    // single load: written two cycles after push
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12345678);
    chk("ld1.mem_ready", {31'd0, mem_ready}, 32'd1);
    idle();
    chk_cnt_is("ld1.q", 1);
    chk_wr("ld1.wait", 1'b0, 5'd5, 32'hDEADBEEF);
    idle();
    chk_wr("ld1.wr", 1'b1, 5'd7, 32'h12345678);
    chk_cnt_is("ld1.drain", 0);
    idle();
    chk_wr("ld1.idle", 1'b0, 5'd7, 32'h12345678);

    // starvation guard: 3 ALU wins, then load forced, ALU retried
    drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd9, 32'hAAAA0009);
    chk("stv.r1", {31'd0, alu_ready}, 32'd1);
    drive(1'b1, 5'd2, 32'h200, 1'b0, 5'd0, 32'h0);
    chk("stv.r2", {31'd0, alu_ready}, 32'd1);
    chk_cnt_is("stv.q", 1);
    chk_wr("stv.w1", 1'b1, 5'd1, 32'h100);
    drive(1'b1, 5'd3, 32'h300, 1'b0, 5'd0, 32'h0);
    chk("stv.r3", {31'd0, alu_ready}, 32'd1);
    chk_wr("stv.w2", 1'b1, 5'd2, 32'h200);
    drive(1'b1, 5'd4, 32'h400, 1'b0, 5'd0, 32'h0);
    chk("stv.r4", {31'd0, alu_ready}, 32'd1);
    chk_wr("stv.w3", 1'b1, 5'd3, 32'h300);
    drive(1'b1, 5'd5, 32'h500, 1'b0, 5'd0, 32'h0);
    chk("stv.force", {31'd0, alu_ready}, 32'd0);
    chk_wr("stv.w4", 1'b1, 5'd4, 32'h400);
    drive(1'b1, 5'd5, 32'h500, 1'b0, 5'd0, 32'h0);
    chk("stv.retry", {31'd0, alu_ready}, 32'd1);
    chk_wr("stv.wld", 1'b1, 5'd9, 32'hAAAA0009);
    chk_cnt_is("stv.q0", 0);
    idle();
    chk_wr("stv.w5", 1'b1, 5'd5, 32'h500);
    idle();
    chk_wr("stv.idle", 1'b0, 5'd5, 32'h500);

    // five loads into a 4-deep FIFO under ALU traffic
    drive(1'b1, 5'd20, 32'hA0000000, 1'b1, 5'd11, 32'hB0000001);
    chk("ff.mr0", {31'd0, mem_ready}, 32'd1);
    drive(1'b1, 5'd21, 32'hA0000001, 1'b1, 5'd12, 32'hB0000002);
    chk_cnt_is("ff.c1", 1);
    chk_wr("ff.w0", 1'b1, 5'd20, 32'hA0000000);
    drive(1'b1, 5'd22, 32'hA0000002, 1'b1, 5'd13, 32'hB0000003);
    chk_cnt_is("ff.c2", 2);
    chk_wr("ff.w1", 1'b1, 5'd21, 32'hA0000001);
    drive(1'b1, 5'd23, 32'hA0000003, 1'b1, 5'd14, 32'hB0000004);
    chk_cnt_is("ff.c3", 3);
    chk("ff.mr3", {31'd0, mem_ready}, 32'd1);
    chk_wr("ff.w2", 1'b1, 5'd22, 32'hA0000002);
    drive(1'b1, 5'd24, 32'hA0000004, 1'b1, 5'd15, 32'hB0000005);
    chk_cnt_is("ff.c4", 4);
    chk("ff.full", {31'd0, mem_ready}, 32'd0);
    chk("ff.force", {31'd0, alu_ready}, 32'd0);
    chk_wr("ff.w3", 1'b1, 5'd23, 32'hA0000003);
    drive(1'b1, 5'd24, 32'hA0000004, 1'b1, 5'd15, 32'hB0000005);
    chk_cnt_is("ff.c5", 3);
    chk("ff.mr5", {31'd0, mem_ready}, 32'd1);
    chk("ff.ar5", {31'd0, alu_ready}, 32'd1);
    chk_wr("ff.l1", 1'b1, 5'd11, 32'hB0000001);
    idle();
    chk_cnt_is("ff.c6", 4);
    chk("ff.full6", {31'd0, mem_ready}, 32'd0);
    chk_wr("ff.w4", 1'b1, 5'd24, 32'hA0000004);
    idle();
    chk_cnt_is("ff.c7", 3);
    chk_wr("ff.l2", 1'b1, 5'd12, 32'hB0000002);
    idle();
    chk_wr("ff.l3", 1'b1, 5'd13, 32'hB0000003);
    idle();
    chk_wr("ff.l4", 1'b1, 5'd14, 32'hB0000004);
    idle();
    chk_wr("ff.l5", 1'b1, 5'd15, 32'hB0000005);
    chk_cnt_is("ff.c10", 0);
    chk("ff.busy", {31'd0, busy}, 32'd1);
    idle();
    chk_wr("ff.idle", 1'b0, 5'd15, 32'hB0000005);
    chk("ff.busy0", {31'd0, busy}, 32'd0);

    // x0 destinations are consumed silently
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0);
    chk("x0.alu_ready", {31'd0, alu_ready}, 32'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
    chk("x0.mem_ready", {31'd0, mem_ready}, 32'd1);
    chk_wr("x0.alu", 1'b0, 5'd0, 32'hFFFFFFFF);
    idle();
    chk_cnt_is("x0.q", 1);
    chk("x0.busy", {31'd0, busy}, 32'd1);
    idle();
    chk_cnt_is("x0.pop", 0);
    chk_wr("x0.ld", 1'b0, 5'd0, 32'h55);
    chk("x0.busy0", {31'd0, busy}, 32'd0);

    // asynchronous reset discards queued loads
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd16, 32'hC1);
    drive(1'b1, 5'd2, 32'h12, 1'b1, 5'd17, 32'hC2);
    drive(1'b1, 5'd3, 32'h13, 1'b1, 5'd18, 32'hC3);
    drive(1'b1, 5'd4, 32'h14, 1'b0, 5'd0, 32'h0);
    chk_cnt_is("ar.q3", 3);
    chk("ar.alu_ready", {31'd0, alu_ready}, 32'd1);
    chk_wr("ar.pre", 1'b1, 5'd3, 32'h13);
    reset = 1'b1;
    alu_valid = 1'b0;
    #1;
    chk_cnt_is("ar.now", 0);
    chk_wr("ar.now", 1'b0, 5'd0, 32'h0);
    chk("ar.busy", {31'd0, busy}, 32'd0);
    chk("ar.mem_ready", {31'd0, mem_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    idle();
    idle();
    chk_wr("ar.after", 1'b0, 5'd0, 32'h0);
    chk_cnt_is("ar.after", 0);
    chk("ar.busy_after", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
